// File: rtl/mac_rx_header_align.sv
// RX XGMII lane aligner: realigns lane-3 starts so FB always exits in lane 7.
// Optional saturating stats counters when MAC_RX_ALIGN_STATS_EN is defined.
module mac_rx_header_align #(
  parameter logic [7:0] P_IDLE  = 8'h07,
  parameter logic [7:0] P_START = 8'hFB,
  parameter logic [7:0] P_TERM  = 8'hFD
`ifdef MAC_RX_ALIGN_STATS_EN
  , parameter int P_CNT_W = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_xgmii_rxd,
  input  logic [7:0]  i_xgmii_rxc,
  output logic [63:0] o_xgmii_rxd,
  output logic [7:0]  o_xgmii_rxc,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_align_err
`ifdef MAC_RX_ALIGN_STATS_EN
  ,
  output logic [P_CNT_W-1:0] o_frame_cnt,
  output logic [P_CNT_W-1:0] o_shift_cnt,
  output logic [P_CNT_W-1:0] o_err_cnt
`endif
);

  localparam logic [63:0] L_IDLE_W = {8{P_IDLE}};
  localparam logic [31:0] L_IDLE_H = {4{P_IDLE}};

  logic [63:0] d1_d;
  logic [63:0] d2_d;
  logic [7:0]  d1_c;
  logic [7:0]  d2_c;
  logic        r_shift;

  logic        sof7;
  logic        sof3;
  logic        in_err;
  logic        nxt_shift;
  logic [63:0] nxt_d;
  logic [7:0]  nxt_c;
  logic        nxt_sof;
  logic        nxt_eof;

  // Start detection on the word currently held in d1
  always_comb begin
    sof7 = (d1_d[63:56] == P_START) && d1_c[7];
    sof3 = (d1_d[31:24] == P_START) && d1_c[3];
  end

  // Misplaced start: control FB in any lane other than 7 or 3
  always_comb begin
    in_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k != 7 && k != 3 && i_xgmii_rxc[k] &&
          i_xgmii_rxd[8*k +: 8] == P_START) begin
        in_err = 1'b1;
      end
    end
  end

  // Mode update: lane-7 start wins over a simultaneous lane-3 start
  always_comb begin
    nxt_shift = r_shift;
    if (sof7) begin
      nxt_shift = 1'b0;
    end else if (sof3) begin
      nxt_shift = 1'b1;
    end
  end

  // Output mux; idle fill stops the new FB word appearing twice
  always_comb begin
    nxt_d = d2_d;
    nxt_c = d2_c;
    if (r_shift && sof7) begin
      nxt_d = {d2_d[31:0], L_IDLE_H};
      nxt_c = {d2_c[3:0], 4'hF};
    end else if (r_shift) begin
      nxt_d = {d2_d[31:0], d1_d[63:32]};
      nxt_c = {d2_c[3:0], d1_c[7:4]};
    end
  end

  // Frame markers decoded from the word about to be registered out
  always_comb begin
    nxt_sof = (nxt_d[63:56] == P_START) && nxt_c[7];
    nxt_eof = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (nxt_c[k] && nxt_d[8*k +: 8] == P_TERM) begin
        nxt_eof = 1'b1;
      end
    end
  end

  // Delay line, mode register and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d1_d        <= L_IDLE_W;
      d1_c        <= 8'hFF;
      d2_d        <= L_IDLE_W;
      d2_c        <= 8'hFF;
      r_shift     <= 1'b0;
      o_xgmii_rxd <= L_IDLE_W;
      o_xgmii_rxc <= 8'hFF;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_align_err <= 1'b0;
    end else begin
      d1_d        <= i_xgmii_rxd;
      d1_c        <= i_xgmii_rxc;
      d2_d        <= d1_d;
      d2_c        <= d1_c;
      r_shift     <= nxt_shift;
      o_xgmii_rxd <= nxt_d;
      o_xgmii_rxc <= nxt_c;
      o_sof       <= nxt_sof;
      o_eof       <= nxt_eof;
      o_align_err <= in_err;
    end
  end

`ifdef MAC_RX_ALIGN_STATS_EN
  // Saturating statistics; o_align_err is high while the bad word is in d1
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_shift_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      if ((sof7 || sof3) && o_frame_cnt != '1) begin
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
      if (!sof7 && sof3 && o_shift_cnt != '1) begin
        o_shift_cnt <= o_shift_cnt + 1'b1;
      end
      if (o_align_err && o_err_cnt != '1) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
